// File: rtl/axi_bw_resp_router.sv
// AXI B-channel backward router: decodes the routing field above the master ID,
// strips it and buffers each response in a per-destination FIFO.
module axi_bw_resp_router #(
  parameter int unsigned N_TARG_PORT = 3,
  parameter int unsigned AXI_ID_IN   = 3,
  parameter int unsigned ROUTE_W     = $clog2(N_TARG_PORT),
  parameter int unsigned AXI_ID_OUT  = AXI_ID_IN + ROUTE_W,
  parameter int unsigned AXI_USER_W  = 6,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [AXI_ID_OUT-1:0]             bid_i,
  input  logic [1:0]                        bresp_i,
  input  logic [AXI_USER_W-1:0]             buser_i,
  input  logic                              bvalid_i,
  output logic                              bready_o,
  output logic [N_TARG_PORT*AXI_ID_IN-1:0]  bid_o,
  output logic [N_TARG_PORT*2-1:0]          bresp_o,
  output logic [N_TARG_PORT*AXI_USER_W-1:0] buser_o,
  output logic [N_TARG_PORT-1:0]            bvalid_o,
  input  logic [N_TARG_PORT-1:0]            bready_i,
  output logic                              route_err_o,
  output logic [7:0]                        drop_cnt_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [AXI_ID_IN-1:0]  id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } entry_t;

  entry_t           mem     [N_TARG_PORT][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr    [N_TARG_PORT];
  logic [PTR_W-1:0] rptr    [N_TARG_PORT];
  logic [CNT_W-1:0] cnt     [N_TARG_PORT];
  logic [CNT_W-1:0] cnt_nxt [N_TARG_PORT];
  logic [N_TARG_PORT-1:0] full_q, empty_q, push, pop;

  logic [ROUTE_W-1:0] route;
  logic               route_ok;
  logic               drop;

  assign route    = bid_i[AXI_ID_OUT-1:AXI_ID_IN];
  assign route_ok = (32'(route) < N_TARG_PORT);
  assign drop     = bvalid_i && !route_ok;

  // Ready depends only on the decoded route and registered fullness; out-of-range routes are always sunk.
  always_comb begin
    bready_o = 1'b1;
    push     = '0;
    for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
      if (route_ok && (route == ROUTE_W'(p))) begin
        if (full_q[p]) bready_o = 1'b0;
        push[p] = bvalid_i && !full_q[p];
      end
    end
    pop = bready_i & ~empty_q;
  end

  always_comb begin
    for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
      cnt_nxt[p] = cnt[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
    end
  end

  // Per-port pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
        wptr[p] <= '0;
        rptr[p] <= '0;
        cnt[p]  <= '0;
      end
      full_q  <= '0;
      empty_q <= '1;
    end else begin
      for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
        if (push[p]) wptr[p] <= wptr[p] + 1'b1;
        if (pop[p])  rptr[p] <= rptr[p] + 1'b1;
        cnt[p]     <= cnt_nxt[p];
        full_q[p]  <= (cnt_nxt[p] == CNT_W'(FIFO_DEPTH));
        empty_q[p] <= (cnt_nxt[p] == '0);
      end
    end
  end

  // Payload storage carries no reset; it is only read once written.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
      if (push[p]) begin
        mem[p][wptr[p]] <= '{id: bid_i[AXI_ID_IN-1:0], resp: bresp_i, user: buser_i};
      end
    end
  end

  always_comb begin
    bid_o   = '0;
    bresp_o = '0;
    buser_o = '0;
    for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
      bid_o[p*AXI_ID_IN +: AXI_ID_IN]    = mem[p][rptr[p]].id;
      bresp_o[p*2 +: 2]                  = mem[p][rptr[p]].resp;
      buser_o[p*AXI_USER_W +: AXI_USER_W] = mem[p][rptr[p]].user;
    end
  end

  assign bvalid_o = ~empty_q;

  // Drop reporting for out-of-range routes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_err_o <= 1'b0;
      drop_cnt_o  <= 8'd0;
    end else begin
      route_err_o <= drop;
      if (drop && (drop_cnt_o != 8'hFF)) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_bw_resp_router.sv
// Directed self-checking bench for axi_bw_resp_router (N=3, ID_IN=3, USER=6, DEPTH=2).
module tb_axi_bw_resp_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  bid_i;
  logic [1:0]  bresp_i;
  logic [5:0]  buser_i;
  logic        bvalid_i;
  logic        bready_o;
  logic [8:0]  bid_o;
  logic [5:0]  bresp_o;
  logic [17:0] buser_o;
  logic [2:0]  bvalid_o;
  logic [2:0]  bready_i;
  logic        route_err_o;
  logic [7:0]  drop_cnt_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  axi_bw_resp_router #(
    .N_TARG_PORT(3), .AXI_ID_IN(3), .AXI_USER_W(6), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i),
    .bvalid_i(bvalid_i), .bready_o(bready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o),
    .bvalid_o(bvalid_o), .bready_i(bready_i),
    .route_err_o(route_err_o), .drop_cnt_o(drop_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] id, input logic [1:0] resp, input logic [5:0] user);
    bid_i    = id;
    bresp_i  = resp;
    buser_i  = user;
    bvalid_i = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; bid_i = '0; bresp_i = '0; buser_i = '0; bvalid_i = 1'b0; bready_i = '0;
    repeat (3) step();
    chk("rst_bvalid", 32'(bvalid_o), 32'h0);
    chk("rst_err", 32'(route_err_o), 32'h0);
    chk("rst_drop", 32'(drop_cnt_o), 32'h0);
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bid_i = {2'(r), 3'b000};
      #1;
      chk($sformatf("rst_bready_r%0d", r), 32'(bready_o), 32'h1);
    end

    // Single routing to port 1
    step();
    drive(5'b01_101, 2'b10, 6'h2A);
    #1 chk("single_bready", 32'(bready_o), 32'h1);
    step();
    bvalid_i = 1'b0;
    chk("single_bvalid", 32'(bvalid_o), 32'b010);
    chk("single_bid1", 32'(bid_o[5:3]), 32'b101);
    chk("single_bresp1", 32'(bresp_o[3:2]), 32'b10);
    chk("single_buser1", 32'(buser_o[11:6]), 32'h2A);
    bready_i = 3'b010;
    step();
    bready_i = 3'b000;
    chk("single_popped", 32'(bvalid_o), 32'b000);

    // Back-pressure on port 0
    drive(5'b00_001, 2'b00, 6'h01);
    #1 chk("bp_bready1", 32'(bready_o), 32'h1);
    step();
    drive(5'b00_010, 2'b01, 6'h02);
    #1 chk("bp_bready2", 32'(bready_o), 32'h1);
    step();
    drive(5'b00_011, 2'b11, 6'h03);
    #1 chk("bp_bready3_stall", 32'(bready_o), 32'h0);
    chk("bp_head0", 32'(bid_o[2:0]), 32'b001);

    // Port independence: route 2 passes while port 0 is full
    drive(5'b10_110, 2'b01, 6'h06);
    #1 chk("ind_bready", 32'(bready_o), 32'h1);
    step();
    bvalid_i = 1'b0;
    chk("ind_bvalid", 32'(bvalid_o), 32'b101);
    chk("ind_bid2", 32'(bid_o[8:6]), 32'b110);
    chk("ind_bid0_held", 32'(bid_o[2:0]), 32'b001);
    bready_i = 3'b100;
    step();
    bready_i = 3'b000;
    chk("ind_pop2", 32'(bvalid_o), 32'b001);

    // Release port 0: third response enters as second leaves, order kept
    drive(5'b00_011, 2'b11, 6'h03);
    #1 chk("bp_still_full", 32'(bready_o), 32'h0);
    bready_i = 3'b001;
    step();
    chk("bp_head2", 32'(bid_o[2:0]), 32'b010);
    chk("bp_resp2", 32'(bresp_o[1:0]), 32'b01);
    chk("bp_bready_free", 32'(bready_o), 32'h1);
    step();
    bvalid_i = 1'b0;
    chk("bp_head3", 32'(bid_o[2:0]), 32'b011);
    chk("bp_resp3", 32'(bresp_o[1:0]), 32'b11);
    chk("bp_valid3", 32'(bvalid_o), 32'b001);
    step();
    bready_i = 3'b000;
    chk("bp_drained", 32'(bvalid_o), 32'b000);

    // Simultaneous push/pop on port 1
    drive(5'b01_111, 2'b00, 6'h11);
    step();
    chk("pp_first", 32'(bid_o[5:3]), 32'b111);
    drive(5'b01_100, 2'b01, 6'h22);
    bready_i = 3'b010;
    step();
    bvalid_i = 1'b0;
    chk("pp_valid", 32'(bvalid_o), 32'b010);
    chk("pp_bid1", 32'(bid_o[5:3]), 32'b100);
    chk("pp_buser1", 32'(buser_o[11:6]), 32'h22);
    step();
    bready_i = 3'b000;
    chk("pp_drained", 32'(bvalid_o), 32'b000);

    // Out-of-range route
    drive(5'b11_000, 2'b00, 6'h00);
    #1 chk("oor_bready", 32'(bready_o), 32'h1);
    step();
    bvalid_i = 1'b0;
    chk("oor_err", 32'(route_err_o), 32'h1);
    chk("oor_no_valid", 32'(bvalid_o), 32'b000);
    chk("oor_cnt1", 32'(drop_cnt_o), 32'd1);
    step();
    chk("oor_err_clear", 32'(route_err_o), 32'h0);
    bvalid_i = 1'b1;
    repeat (299) step();
    bvalid_i = 1'b0;
    chk("oor_saturate", 32'(drop_cnt_o), 32'd255);
    chk("oor_sat_no_valid", 32'(bvalid_o), 32'b000);

    // Reset mid-stream with port 0 full
    drive(5'b00_101, 2'b00, 6'h05);
    step();
    drive(5'b00_110, 2'b00, 6'h06);
    step();
    bvalid_i = 1'b0;
    chk("mid_full", 32'(bvalid_o), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", 32'(bvalid_o), 32'b000);
    chk("mid_rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("mid_rst_err", 32'(route_err_o), 32'h0);
    step();
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bid_i = {2'(r), 3'b000};
      #1;
      chk($sformatf("mid_bready_r%0d", r), 32'(bready_o), 32'h1);
    end
    step();
    chk("mid_after_idle", 32'(bvalid_o), 32'b000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axi_bw_resp_router.md
Name: axi_bw_resp_router

Overview:
Next-generation write-response (B channel) backward router for the AXI node. It decodes the routing field that the node appended above the master ID, strips it, and delivers each response to one of N_TARG_PORT slave-side ports through a per-port buffer. The per-port buffers remove the combinational bready path from slave ports back to the master port and let a stalled port absorb responses without blocking other ports. Responses whose routing field is out of range are sunk and reported, not sent to a wrong port.

Parameters:
N_TARG_PORT, 3, number of destination ports (>=2)
AXI_ID_IN, 3, ID width delivered to each destination port
ROUTE_W, $clog2(N_TARG_PORT), routing field width (derived; do not override)
AXI_ID_OUT, AXI_ID_IN+ROUTE_W, incoming ID width
AXI_USER_W, 6, B user width
FIFO_DEPTH, 2, entries per port buffer (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
bid_i  in  AXI_ID_OUT  incoming response ID; routing field is bid_i[AXI_ID_OUT-1:AXI_ID_IN]
bresp_i  in  2  incoming response code
buser_i  in  AXI_USER_W  incoming user bits
bvalid_i  in  1  incoming valid
bready_o  out  1  incoming ready
bid_o  out  N_TARG_PORT*AXI_ID_IN  per-port stripped ID, port p at slice p
bresp_o  out  N_TARG_PORT*2  per-port response code
buser_o  out  N_TARG_PORT*AXI_USER_W  per-port user bits
bvalid_o  out  N_TARG_PORT  per-port valid
bready_i  in  N_TARG_PORT  per-port ready
route_err_o  out  1  one-cycle pulse per dropped out-of-range response
drop_cnt_o  out  8  saturating count of dropped responses

Behaviour:
- ROUTE = bid_i[AXI_ID_OUT-1:AXI_ID_IN]; route_ok = (ROUTE < N_TARG_PORT).
- Per port p: FIFO of FIFO_DEPTH entries {id[AXI_ID_IN-1:0], resp, user}, with registered count and full/empty flags.
- bready_o = route_ok ? !full[ROUTE] : 1. bready_o depends only on bid_i and registered state. There is no path from bready_i to bready_o.
- bready_o is driven independently of bvalid_i. The master side must not rely on bvalid_i gating it.
- Push to FIFO[ROUTE] when bvalid_i && bready_o && route_ok.
- Pop port p when bvalid_o[p] && bready_i[p]. bvalid_o[p] = !empty[p]. Outputs come from the FIFO head.
- Latency: a response accepted in cycle t appears on bvalid_o in cycle t+1 at the earliest.
- Ordering: per-port FIFO order is preserved. No ordering is guaranteed across ports.
- Port independence: a full port stalls the input only while the input's ROUTE targets that port.
- Full boundary: full is evaluated on the registered count, without pop look-ahead. A pop and a push in the same cycle are both performed when the port is not full. A push into a full port is impossible because bready_o is 0.
- Empty boundary: a push into an empty port makes bvalid_o high the next cycle. Write-through bypass is not allowed.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Out-of-range route (only possible when N_TARG_PORT is not a power of 2):
  - the response is accepted (bready_o=1) and discarded;
  - route_err_o is 1 in the following cycle;
  - drop_cnt_o increments and saturates at 255.
- bid_o, bresp_o and buser_o are don't-care while the matching bvalid_o is 0. No X may propagate while bvalid_o is 1.
- AXI stability: once bvalid_o[p] is 1 it stays 1, with stable payload, until the pop.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - all FIFOs empty; bvalid_o=0; route_err_o=0; drop_cnt_o=0;
  - bready_o reflects the empty state once the reset is released;
  - reset mid-operation discards all buffered responses without popping.

Test Plan:
- Single routing: N=3, bid_i=5'b01_101, bresp=2'b10 -> one cycle later bvalid_o=3'b010, bid_o slice1=3'b101, bresp slice1=2'b10; other ports stay idle.
- Back-pressure: hold bready_i[0]=0 and send 3 responses to port 0 with FIFO_DEPTH=2 -> first 2 accepted, bready_o=0 on the 3rd. Release bready_i[0] -> 3 responses delivered in order.
- Port independence: port 0 full and stalled, then a response with ROUTE=2 -> bready_o=1, delivered on port 2 in the next cycle while port 0 still holds 2 entries.
- Out-of-range: N=3, ROUTE=2'b11 -> bready_o=1, no bvalid_o, route_err_o pulses once, drop_cnt_o=1. Send 300 such responses -> drop_cnt_o=255.
- Simultaneous push/pop: port 1 holds 1 entry with bready_i[1]=1 and a new push arrives -> count stays 1, bvalid_o[1] stays high, next payload follows in order.
- Reset mid-stream: port 0 holds 2 entries, assert rst_n=0 asynchronously -> bvalid_o=0 immediately, drop_cnt_o=0. After release, bready_o=1 for all in-range routes.
